// File: rtl/sat_simd_unit.sv
// sat_simd_unit: saturating ADD/SUB, lane-wise saturating PADD and a lane-sum reduction (RED).
// Define SAT_SIMD_RED_EN to build RED; without it op 11 completes in one cycle flagged as err.
module sat_simd_unit #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     ovfl,
  output logic [WIDTH/LANE_W-1:0]  lane_ovfl,
  output logic                     err
);

  localparam int NLANES = WIDTH / LANE_W;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PADD = 2'b10;
  localparam logic [1:0] OP_RED  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b10;
`ifdef SAT_SIMD_RED_EN
  localparam logic [1:0] S_RED  = 2'b01;
  localparam int         CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLANES - 1);
`endif

  localparam logic [WIDTH-1:0]  WORD_MIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [LANE_W-1:0] LANE_MIN = LANE_W'(1) << (LANE_W - 1);

  if (WIDTH % LANE_W != 0) begin : g_bad_lane_w
    $error("sat_simd_unit: WIDTH must be a multiple of LANE_W");
  end

  // Full-width add/sub with clamp; returns {overflow, value}.
  function automatic logic [WIDTH:0] sat_addsub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             sub);
    logic signed [WIDTH:0] xe;
    logic signed [WIDTH:0] ye;
    logic signed [WIDTH:0] s;
    xe = {x[WIDTH-1], x};
    ye = {y[WIDTH-1], y};
    s  = sub ? (xe - ye) : (xe + ye);
    if (s[WIDTH] != s[WIDTH-1])
      return {1'b1, (s[WIDTH] ? WORD_MIN : ~WORD_MIN)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  // Independent per-lane add with clamp; returns {lane overflow flags, packed lanes}.
  function automatic logic [NLANES+WIDTH-1:0] sat_padd(input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0]       r;
    logic [NLANES-1:0]      lo;
    logic signed [LANE_W:0] xe;
    logic signed [LANE_W:0] ye;
    logic signed [LANE_W:0] s;
    r  = '0;
    lo = '0;
    for (int i = 0; i < NLANES; i++) begin
      xe = {x[i*LANE_W+LANE_W-1], x[i*LANE_W +: LANE_W]};
      ye = {y[i*LANE_W+LANE_W-1], y[i*LANE_W +: LANE_W]};
      s  = xe + ye;
      lo[i] = (s[LANE_W] != s[LANE_W-1]);
      if (lo[i])
        r[i*LANE_W +: LANE_W] = s[LANE_W] ? LANE_MIN : ~LANE_MIN;
      else
        r[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
    end
    return {lo, r};
  endfunction

`ifdef SAT_SIMD_RED_EN
  function automatic logic signed [WIDTH-1:0] sext_lane(input logic [WIDTH-1:0] x,
                                                        input int               idx);
    logic signed [LANE_W-1:0] l;
    l = x[idx*LANE_W +: LANE_W];
    return WIDTH'(l);
  endfunction
`endif

  logic [1:0]              state;
  logic                    accept;
  logic [WIDTH:0]          addsub_res;
  logic [NLANES+WIDTH-1:0] padd_res;

  logic [WIDTH-1:0]        res_p1;
  logic                    ovfl_p1;
  logic [NLANES-1:0]       lane_ovfl_p1;
  logic                    err_p1;

  assign in_ready   = (state == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign addsub_res = sat_addsub(a, b, op == OP_SUB);
  assign padd_res   = sat_padd(a, b);

`ifdef SAT_SIMD_RED_EN
  logic [WIDTH-1:0]        red_a_p0;
  logic [WIDTH-1:0]        red_b_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [WIDTH-1:0] acc_p0;
  logic signed [WIDTH-1:0] lane_sum;

  assign lane_sum = sext_lane(red_a_p0, int'(cnt_p0)) + sext_lane(red_b_p0, int'(cnt_p0));

  // Stage 0: operands held for the whole reduction
  always_ff @(posedge clk) begin
    if (accept && op == OP_RED) begin
      red_a_p0 <= a;
      red_b_p0 <= b;
    end
  end

  // Counter parks on the last lane instead of wrapping; the FSM leaves RED there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept && op == OP_RED) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (state == S_RED) begin
      acc_p0 <= acc_p0 + lane_sum;
      if (cnt_p0 != CNT_LAST)
        cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end
`endif

  // Stage 1: registered result, held through HOLD until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      res_p1       <= '0;
      ovfl_p1      <= 1'b0;
      lane_ovfl_p1 <= '0;
      err_p1       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_ADD, OP_SUB: begin
                res_p1       <= addsub_res[WIDTH-1:0];
                ovfl_p1      <= addsub_res[WIDTH];
                lane_ovfl_p1 <= '0;
                err_p1       <= 1'b0;
                state        <= S_HOLD;
              end
              OP_PADD: begin
                res_p1       <= padd_res[WIDTH-1:0];
                ovfl_p1      <= |padd_res[NLANES+WIDTH-1:WIDTH];
                lane_ovfl_p1 <= padd_res[NLANES+WIDTH-1:WIDTH];
                err_p1       <= 1'b0;
                state        <= S_HOLD;
              end
              OP_RED: begin
`ifdef SAT_SIMD_RED_EN
                state        <= S_RED;
`else
                res_p1       <= '0;
                ovfl_p1      <= 1'b0;
                lane_ovfl_p1 <= '0;
                err_p1       <= 1'b1;
                state        <= S_HOLD;
`endif
              end
            endcase
          end
        end
`ifdef SAT_SIMD_RED_EN
        S_RED: begin
          if (cnt_p0 == CNT_LAST) begin
            res_p1       <= acc_p0 + lane_sum;
            ovfl_p1      <= 1'b0;
            lane_ovfl_p1 <= '0;
            err_p1       <= 1'b0;
            state        <= S_HOLD;
          end
        end
`endif
        S_HOLD: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (state == S_HOLD);
  assign result    = res_p1;
  assign ovfl      = ovfl_p1;
  assign lane_ovfl = lane_ovfl_p1;
  assign err       = err_p1;

endmodule
